// File: rtl/cpu_controller.sv
// Eight-phase instruction-cycle sequencer for the small CPU.
// Drives fetch, ALU, accumulator, PC and memory strobes from the opcode.
module cpu_controller #(
  parameter bit HLT_STICKY = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic [2:0] OPCODE,
  input  logic       ZERO,
  output logic       RD,
  output logic       WR,
  output logic       LOAD_IR,
  output logic       INC_PC,
  output logic       LOAD_PC,
  output logic       ALU_ENA,
  output logic       LOAD_ACC,
  output logic       DATACTL_ENA,
  output logic       HALT
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    P0, P1, P2, P3, P4, P5, P6, P7
  } phase_e;

  typedef enum logic {
    RUNNING, HALTED
  } state_e;

  typedef struct packed {
    logic rd;
    logic wr;
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic alu_ena;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  phase_e     r_phase, w_nphase;
  state_e     r_state, w_nstate;
  ctl_t       r_out, w_nout;
  logic [2:0] r_op, w_op;
  logic       r_skip, w_skip;
  logic       w_alu;

  // Outputs are computed for the phase being entered, so each
  // strobe is registered and covers exactly that phase.
  always_comb begin
    w_nphase = r_phase;
    w_nstate = r_state;
    w_nout   = '0;
    w_op     = (r_phase == P1) ? OPCODE : r_op;
    w_skip   = (r_phase == P3) ? ((r_op == OP_SKZ) && ZERO) : r_skip;
    w_alu    = (w_op == OP_ADD) || (w_op == OP_ANDD) ||
               (w_op == OP_XORR) || (w_op == OP_LDA);
    if (r_state == HALTED) begin
      w_nout.halt = 1'b1;
    end else begin
      unique case (r_phase)
        P7: begin
          // r_out.halt is only set in the P7 that ends an HLT
          if (HLT_STICKY && r_out.halt) begin
            w_nstate    = HALTED;
            w_nout.halt = 1'b1;
          end else if (RUN) begin
            w_nphase       = P0;
            w_nout.rd      = 1'b1;
            w_nout.load_ir = 1'b1;
            w_nout.inc_pc  = 1'b1;
          end
        end
        P0: begin
          w_nphase       = P1;
          w_nout.rd      = 1'b1;
          w_nout.load_ir = 1'b1;
          w_nout.inc_pc  = 1'b1;
        end
        P1: begin
          w_nphase    = P2;
          w_nout.halt = (w_op == OP_HLT);
        end
        P2: begin
          w_nphase  = P3;
          w_nout.rd = w_alu;
        end
        P3: begin
          w_nphase           = P4;
          w_nout.rd          = w_alu;
          w_nout.alu_ena     = w_alu;
          w_nout.inc_pc      = w_skip;
          w_nout.load_pc     = (w_op == OP_JMP);
          w_nout.datactl_ena = (w_op == OP_STO);
        end
        P4: begin
          w_nphase           = P5;
          w_nout.rd          = w_alu;
          w_nout.load_acc    = w_alu;
          w_nout.inc_pc      = w_skip;
          w_nout.load_pc     = (w_op == OP_JMP);
          w_nout.wr          = (w_op == OP_STO);
          w_nout.datactl_ena = (w_op == OP_STO);
        end
        P5: begin
          w_nphase           = P6;
          w_nout.datactl_ena = (w_op == OP_STO);
          w_nout.halt        = (w_op == OP_HLT);
        end
        P6: begin
          w_nphase    = P7;
          w_nout.halt = (w_op == OP_HLT);
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_phase <= P7;
      r_state <= RUNNING;
      r_out   <= '0;
      r_op    <= OP_SKZ;
      r_skip  <= 1'b0;
    end else begin
      r_phase <= w_nphase;
      r_state <= w_nstate;
      r_out   <= w_nout;
      r_op    <= w_op;
      r_skip  <= w_skip;
    end
  end

  assign RD          = r_out.rd;
  assign WR          = r_out.wr;
  assign LOAD_IR     = r_out.load_ir;
  assign INC_PC      = r_out.inc_pc;
  assign LOAD_PC     = r_out.load_pc;
  assign ALU_ENA     = r_out.alu_ena;
  assign LOAD_ACC    = r_out.load_acc;
  assign DATACTL_ENA = r_out.datactl_ena;
  assign HALT        = r_out.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: non-sticky and sticky HLT instances side by side.
// Expected strobe vectors are queued per cycle and popped at sample time.
module tb_cpu_controller;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RUN = 1'b1;
  logic       ZERO = 1'b0;
  logic [2:0] OPCODE = 3'b000;

  logic [8:0] o0, o1;

  // {RD,WR,LOAD_IR,INC_PC,LOAD_PC,ALU_ENA,LOAD_ACC,DATACTL_ENA,HALT}
  localparam int B_RD = 8;
  localparam int B_WR = 7;
  localparam int B_IR = 6;
  localparam int B_INC = 5;
  localparam int B_LPC = 4;
  localparam int B_ALU = 3;
  localparam int B_ACC = 2;
  localparam int B_DAT = 1;
  localparam int B_HLT = 0;
  localparam logic [8:0] HALT_ONLY = 9'b000000001;

  cpu_controller #(.HLT_STICKY(1'b0)) u0 (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
    .OPCODE(OPCODE), .ZERO(ZERO),
    .RD(o0[8]), .WR(o0[7]), .LOAD_IR(o0[6]),
    .INC_PC(o0[5]), .LOAD_PC(o0[4]),
    .ALU_ENA(o0[3]), .LOAD_ACC(o0[2]),
    .DATACTL_ENA(o0[1]), .HALT(o0[0])
  );

  cpu_controller #(.HLT_STICKY(1'b1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
    .OPCODE(OPCODE), .ZERO(ZERO),
    .RD(o1[8]), .WR(o1[7]), .LOAD_IR(o1[6]),
    .INC_PC(o1[5]), .LOAD_PC(o1[4]),
    .ALU_ENA(o1[3]), .LOAD_ACC(o1[2]),
    .DATACTL_ENA(o1[1]), .HALT(o1[0])
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [8:0] e0;
    logic [8:0] e1;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   h1 = 1'b0;

  task automatic chk(input string tag, input logic [8:0] got,
                     input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [8:0] e0,
                      input logic [8:0] e1);
    exp_t e;
    e.tag = tag;
    e.e0  = e0;
    e.e1  = e1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".u0"}, o0, e.e0);
      chk({e.tag, ".u1"}, o1, e.e1);
    end
  endtask

  function automatic logic [8:0] exp_vec(input logic [2:0] op,
                                         input logic z, input int p);
    logic [8:0] v;
    logic alu, skp, sto, jmp, hlt;
    v   = '0;
    alu = (op == 3'b010) || (op == 3'b011) ||
          (op == 3'b100) || (op == 3'b101);
    skp = (op == 3'b001) && z;
    sto = (op == 3'b110);
    jmp = (op == 3'b111);
    hlt = (op == 3'b000);
    case (p)
      0, 1: begin
        v[B_RD] = 1'b1;
        v[B_IR] = 1'b1;
        v[B_INC] = 1'b1;
      end
      2: v[B_HLT] = hlt;
      3: v[B_RD] = alu;
      4: begin
        v[B_RD]  = alu;
        v[B_ALU] = alu;
        v[B_INC] = skp;
        v[B_LPC] = jmp;
        v[B_DAT] = sto;
      end
      5: begin
        v[B_RD]  = alu;
        v[B_ACC] = alu;
        v[B_INC] = skp;
        v[B_LPC] = jmp;
        v[B_WR]  = sto;
        v[B_DAT] = sto;
      end
      6: begin
        v[B_DAT] = sto;
        v[B_HLT] = hlt;
      end
      default: v[B_HLT] = hlt;
    endcase
    return v;
  endfunction

  // OPCODE and ZERO are scrambled once captured to prove they are ignored.
  task automatic run_instr(input logic [2:0] op, input logic z,
                           input string nm);
    logic [8:0] e;
    OPCODE = op;
    ZERO   = z;
    RUN    = 1'b1;
    for (int p = 0; p < 8; p++) begin
      e = exp_vec(op, z, p);
      step($sformatf("%s.P%0d", nm, p), e, h1 ? HALT_ONLY : e);
      if (p == 2) OPCODE = 3'($urandom_range(7, 0));
      if (p == 4) ZERO = ~ZERO;
    end
  endtask

  initial begin
    logic [8:0] e;
    for (int i = 0; i < 3; i++) step($sformatf("rst%0d", i), '0, '0);
    RST_N = 1'b1;

    run_instr(3'b010, 1'b0, "ADD");
    run_instr(3'b010, 1'b1, "ADDz");
    run_instr(3'b001, 1'b1, "SKZ1");
    run_instr(3'b001, 1'b0, "SKZ0");
    run_instr(3'b011, 1'b0, "ANDD");
    run_instr(3'b100, 1'b1, "XORR");
    run_instr(3'b101, 1'b0, "LDA");
    run_instr(3'b110, 1'b0, "STO");
    run_instr(3'b111, 1'b1, "JMP");

    RUN = 1'b0;
    for (int i = 0; i < 10; i++) step($sformatf("idle%0d", i), '0, '0);
    run_instr(3'b010, 1'b0, "ADDr");

    run_instr(3'b000, 1'b0, "HLT");
    h1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_instr(3'b011, 1'b0, $sformatf("postHLT%0d", i));
    end

    RST_N = 1'b0;
    h1    = 1'b0;
    for (int i = 0; i < 2; i++) step($sformatf("rstB%0d", i), '0, '0);
    RST_N = 1'b1;
    run_instr(3'b101, 1'b0, "LDAr");

    OPCODE = 3'b010;
    ZERO   = 1'b0;
    RUN    = 1'b1;
    for (int p = 0; p < 5; p++) begin
      e = exp_vec(3'b010, 1'b0, p);
      step($sformatf("ABT.P%0d", p), e, e);
    end
    RST_N = 1'b0;
    for (int i = 0; i < 2; i++) step($sformatf("abort%0d", i), '0, '0);
    RST_N = 1'b1;
    run_instr(3'b110, 1'b0, "STOr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
